ahb_resp_mux: RTL and testbench
===============================

Name: ahb_resp_mux

Overview:
- Parametrised AHB-Lite slave-side response multiplexer and default slave for the uncore. Successor to the fixed read/ready/resp mux with its HREADY-enabled select-delay register.
- Takes the address-phase one-hot slave selects from the address decoder and registers them into a data-phase select. Steers HRDATA/HREADY/HRESP from N slaves.
- Adds a protocol-correct two-cycle ERROR response for unmapped accesses, plus an optional hung-slave timeout.

Parameters:
- NSLV, 8, number of slave ports (1..32).
- DW, 64, data width; equals AHBW.
- TMO_CYCLES, 255, wait-state limit before timeout (>=2); used only with the optional feature.

Ports:
- HCLK  in  1  bus clock.
- HRESETn  in  1  reset, asynchronous, active-low.
- HSEL  in  NSLV  address-phase one-hot select from the decoder; all-zero means unmapped.
- HTRANS  in  2  master transfer type.
- HREADYOUT_S  in  NSLV  per-slave ready.
- HRESP_S  in  NSLV  per-slave response.
- HRDATA_S  in  NSLV x DW  per-slave read data, packed [NSLV-1:0][DW-1:0].
- HRDATA  out  DW  muxed read data to the master.
- HREADY  out  1  muxed ready; also fed back to the slaves as HREADY.
- HRESP  out  1  muxed response.
- HSELD  out  NSLV  registered data-phase select.
- MultiSelErr  out  1  sticky flag: more than one HSEL bit was asserted during an accepted transfer.
- TmoErr  out  1  sticky flag: a slave timeout occurred (tied 0 without the feature).
- ErrClr  in  1  synchronous clear of both sticky flags.

Behaviour:
- Reset state: HRESETn low forces state IDLE, HSELD=0, HREADY=1, HRESP=0, HRDATA=0, both sticky flags 0, timeout counter 0. Reset applies asynchronously mid-transfer; no pending ERROR survives reset.
- Address phase accepted: when HREADY=1 and HTRANS[1]=1 (NONSEQ or SEQ).
  - Any HSEL bit set: the lowest set index is loaded into HSELD (one-hot) and the state goes to SLV. If more than one bit is set, MultiSelErr is also set.
  - HSEL all zero: the state goes to ERR1 and HSELD=0.
- HTRANS IDLE/BUSY with HREADY=1: state goes to IDLE, HSELD=0, zero-wait OKAY.
- When HREADY=0, HSELD and the state hold.
- State IDLE: HREADY=1, HRESP=0, HRDATA=0.
- State SLV: HRDATA, HREADY and HRESP come from the slave selected by HSELD, purely combinationally with zero added latency. The next state is decided by the address-phase rules above, evaluated only in the cycle where the slave's HREADYOUT=1.
- State ERR1: HREADY=0, HRESP=1. Always goes to ERR2.
- State ERR2: HREADY=1, HRESP=1, HRDATA=0. Because HREADY=1, ERR2 accepts the next address phase using the rules above, so back-to-back unmapped accesses give repeated ERR1/ERR2 pairs.
- A slave that drives its own ERROR passes through unmodified; the slave is responsible for the two-cycle form.
- Sticky flags: ErrClr clears them. If ErrClr and a set event occur in the same cycle, set wins.
- Width rule: HRDATA is an AND-OR mux over the slaves, gated by HSELD.

Optional Feature:
- Macro: AHB_RESP_MUX_TIMEOUT_EN.
- Enabled:
  - Counter of ceil(log2(TMO_CYCLES+1)) bits. It clears on every accepted address phase and increments in each SLV cycle where the selected HREADYOUT=0.
  - When the counter reaches TMO_CYCLES with HREADYOUT still 0: the state goes to ERR1, TmoErr is set, and HSELD is cleared. Any late response from the hung slave is ignored.
  - If HREADYOUT rises in the same cycle the limit is reached, the slave response wins and no timeout occurs.
- Disabled: no counter is built, TmoErr is tied 0, and a hung slave stalls the bus indefinitely.

Decomposition:
- Shared package (cvw-side ahb package):
  - htrans_t enum: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
  - mux_state_t enum: IDLE, SLV, ERR1, ERR2.
  - Constant AHB_RESP_OKAY=0 / AHB_RESP_ERROR=1.
- One natural sub-module: ahb_onehot_prio, a combinational lowest-index one-hot priority picker with a multi-hit flag. Everything else stays in ahb_resp_mux.

Test Plan:
- Reset release, then NONSEQ with HSEL=8'b0000_0100; slave 2 returns HREADYOUT=1 with data 64'hDEAD_BEEF_0000_0001 -> HRDATA equals that data in the data phase, HSELD=0000_0100, HRESP=0.
- Slave 5 inserts 3 wait states -> HREADY=0 for 3 cycles, then 1; HSELD holds 0010_0000 throughout; a new HSEL presented during the waits is ignored.
- NONSEQ with HSEL=0 -> ERR1 (HREADY=0, HRESP=1) then ERR2 (HREADY=1, HRESP=1). A second unmapped NONSEQ sampled in ERR2 repeats the pair immediately.
- HSEL=8'b0001_0010 on NONSEQ -> slave 1 is selected, MultiSelErr=1. ErrClr pulse -> MultiSelErr=0.
- IDLE with HSEL=0 -> HREADY=1, HRESP=0, no error; assert HRESETn low while in ERR1 -> HREADY=1 and HRESP=0 immediately (asynchronous).
- With AHB_RESP_MUX_TIMEOUT_EN and TMO_CYCLES=4, slave 0 holds HREADYOUT=0 -> after 4 wait cycles: ERR1, ERR2, TmoErr=1. A repeat where HREADYOUT rises exactly at count 4 -> OKAY, TmoErr unchanged.

Source files
------------

// File: rtl/ahb_resp_mux_pkg.sv
// Shared AHB-Lite definitions for the slave-side response multiplexer.
package ahb_resp_mux_pkg;

    // Master transfer type (values are the AHB encodings).
    typedef enum logic [1:0] {
        HT_IDLE   = 2'd0,
        HT_BUSY   = 2'd1,
        HT_NONSEQ = 2'd2,
        HT_SEQ    = 2'd3
    } htrans_t;

    // Data-phase owner of the response path.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SLV  = 2'd1,
        ST_ERR1 = 2'd2,
        ST_ERR2 = 2'd3
    } mux_state_t;

    localparam logic AHB_RESP_OKAY  = 1'b0;
    localparam logic AHB_RESP_ERROR = 1'b1;

    // NONSEQ or SEQ: a real transfer that must be answered.
    function automatic logic htrans_active(htrans_t t);
        return (t == HT_NONSEQ) || (t == HT_SEQ);
    endfunction

endpackage

// File: rtl/ahb_resp_mux_onehot_prio.sv
// Lowest-index one-hot priority picker with a multi-hit flag.
module ahb_onehot_prio #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] onehot_o,
    output logic         any_o,
    output logic         multi_o
);

    // Isolate the lowest set bit; anything left over means more than one requester.
    assign onehot_o = req_i & (~req_i + N'(1));
    assign any_o    = |req_i;
    assign multi_o  = |(req_i & ~onehot_o);

endmodule

// File: rtl/ahb_resp_mux.sv
// AHB-Lite response mux and default slave: registers the address-phase select,
// steers HRDATA/HREADY/HRESP from the selected slave, and answers unmapped
// accesses with a two-cycle ERROR.
// Optional hung-slave timeout: define AHB_RESP_MUX_TIMEOUT_EN.
module ahb_resp_mux
    import ahb_resp_mux_pkg::*;
#(
    parameter int unsigned NSLV       = 8,
    parameter int unsigned DW         = 64,
    parameter int unsigned TMO_CYCLES = 255
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [NSLV-1:0]          HSEL,
    input  logic [1:0]               HTRANS,
    input  logic [NSLV-1:0]          HREADYOUT_S,
    input  logic [NSLV-1:0]          HRESP_S,
    input  logic [NSLV-1:0][DW-1:0]  HRDATA_S,
    output logic [DW-1:0]            HRDATA,
    output logic                     HREADY,
    output logic                     HRESP,
    output logic [NSLV-1:0]          HSELD,
    output logic                     MultiSelErr,
    output logic                     TmoErr,
    input  logic                     ErrClr
);

    if (NSLV < 1 || NSLV > 32) begin : g_bad_nslv
        $error("ahb_resp_mux: NSLV must be 1..32");
    end
    if (TMO_CYCLES < 2) begin : g_bad_tmo
        $error("ahb_resp_mux: TMO_CYCLES must be >= 2");
    end

    mux_state_t      state_q, state_d;
    logic [NSLV-1:0] hseld_q, hseld_d;
    logic            mse_q, mse_d;

    logic [NSLV-1:0] pick;
    logic            any_sel;
    logic            multi_hit;

    logic [DW-1:0]   slv_rdata;
    logic            slv_ready;
    logic            slv_resp;

    ahb_onehot_prio #(.N(NSLV)) u_prio (
        .req_i    (HSEL),
        .onehot_o (pick),
        .any_o    (any_sel),
        .multi_o  (multi_hit)
    );

`ifdef AHB_RESP_MUX_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TMO_CYCLES + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    logic          tmo_hit;

    // Limit reached while the selected slave is still stalling.
    assign tmo_hit = (state_q == ST_SLV) && !slv_ready && (cnt_q == CW'(TMO_CYCLES));
    assign TmoErr  = tmo_q;
`else
    assign TmoErr  = 1'b0;
`endif

    // AND-OR mux of the selected slave's response, gated by the data-phase select.
    always_comb begin
        slv_rdata = '0;
        for (int unsigned i = 0; i < NSLV; i++) begin
            slv_rdata = slv_rdata | (HRDATA_S[i] & {DW{hseld_q[i]}});
        end
        slv_ready = |(HREADYOUT_S & hseld_q);
        slv_resp  = |(HRESP_S & hseld_q);
    end

    // Response to the master for the current data phase.
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = AHB_RESP_OKAY;
        unique case (state_q)
            ST_SLV: begin
                HRDATA = slv_rdata;
                HREADY = slv_ready;
                HRESP  = slv_resp;
            end
            ST_ERR1: begin
                HREADY = 1'b0;
                HRESP  = AHB_RESP_ERROR;
            end
            ST_ERR2: begin
                HRESP  = AHB_RESP_ERROR;
            end
            default: ;
        endcase
    end

    // Next state: ERR1 always completes; otherwise a new address phase is
    // only sampled when HREADY is high.
    always_comb begin
        state_d = state_q;
        hseld_d = hseld_q;
        mse_d   = mse_q & ~ErrClr;
`ifdef AHB_RESP_MUX_TIMEOUT_EN
        tmo_d   = tmo_q & ~ErrClr;
        cnt_d   = cnt_q;
`endif
        if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if (HREADY) begin
            if (htrans_active(htrans_t'(HTRANS))) begin
`ifdef AHB_RESP_MUX_TIMEOUT_EN
                cnt_d = '0;
`endif
                if (any_sel) begin
                    state_d = ST_SLV;
                    hseld_d = pick;
                    if (multi_hit) begin
                        mse_d = 1'b1;
                    end
                end else begin
                    state_d = ST_ERR1;
                    hseld_d = '0;
                end
            end else begin
                state_d = ST_IDLE;
                hseld_d = '0;
            end
        end
`ifdef AHB_RESP_MUX_TIMEOUT_EN
        else if (tmo_hit) begin
            state_d = ST_ERR1;
            hseld_d = '0;
            tmo_d   = 1'b1;
            cnt_d   = '0;
        end else if (state_q == ST_SLV) begin
            cnt_d = cnt_q + CW'(1);
        end
`endif
    end

    // State and flag registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= ST_IDLE;
            hseld_q <= '0;
            mse_q   <= 1'b0;
`ifdef AHB_RESP_MUX_TIMEOUT_EN
            tmo_q   <= 1'b0;
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hseld_q <= hseld_d;
            mse_q   <= mse_d;
`ifdef AHB_RESP_MUX_TIMEOUT_EN
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign HSELD       = hseld_q;
    assign MultiSelErr = mse_q;

endmodule

// File: tb/tb_ahb_resp_mux.sv
// Self-checking bench for ahb_resp_mux: directed vector table, hand-written
// corner sequences and randomized traffic against a transaction-level model.
module tb_ahb_resp_mux;

    localparam int unsigned NSLV = 8;
    localparam int unsigned DW   = 64;
    localparam int unsigned TMO  = 4;

    localparam logic [1:0] IDL = 2'd0;
    localparam logic [1:0] BSY = 2'd1;
    localparam logic [1:0] NSQ = 2'd2;
    localparam logic [1:0] SEQ = 2'd3;

    logic                    HCLK = 1'b0;
    logic                    HRESETn;
    logic [NSLV-1:0]         HSEL;
    logic [1:0]              HTRANS;
    logic [NSLV-1:0]         HREADYOUT_S;
    logic [NSLV-1:0]         HRESP_S;
    logic [NSLV-1:0][DW-1:0] HRDATA_S;
    logic [DW-1:0]           HRDATA;
    logic                    HREADY;
    logic                    HRESP;
    logic [NSLV-1:0]         HSELD;
    logic                    MultiSelErr;
    logic                    TmoErr;
    logic                    ErrClr;

    ahb_resp_mux #(.NSLV(NSLV), .DW(DW), .TMO_CYCLES(TMO)) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HSEL        (HSEL),
        .HTRANS      (HTRANS),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .HRDATA_S    (HRDATA_S),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HSELD       (HSELD),
        .MultiSelErr (MultiSelErr),
        .TmoErr      (TmoErr),
        .ErrClr      (ErrClr)
    );

    always #5 HCLK = ~HCLK;

    int n_checks = 0;
    int n_errors = 0;

    // Transaction-level model: which slave owns the data phase (-1 none),
    // how many ERROR cycles remain, wait cycles seen, sticky flags.
    int   m_sel;
    int   m_err;
    int   m_cnt;
    logic m_mse;
    logic m_tmo;

    typedef struct {
        logic [7:0]  hsel;
        logic [1:0]  htrans;
        logic [7:0]  rdy;
        logic        clr;
        logic        e_ready;
        logic        e_resp;
        logic [7:0]  e_hseld;
        logic [63:0] e_data;
        logic        e_mse;
    } vec_t;

    localparam int NV = 21;
    vec_t tbl [NV];

    function automatic logic [63:0] sdata(input int i);
        if (i == 2) return 64'hDEAD_BEEF_0000_0001;
        return {32'hCAFE_0000 + 32'(i), 32'h1234_5678};
    endfunction

    function automatic vec_t mkv(input logic [7:0] hsel, input logic [1:0] ht,
                                 input logic [7:0] rdy, input logic clr,
                                 input logic er, input logic ers, input logic [7:0] eh,
                                 input logic [63:0] ed, input logic em);
        vec_t v;
        v.hsel = hsel; v.htrans = ht; v.rdy = rdy; v.clr = clr;
        v.e_ready = er; v.e_resp = ers; v.e_hseld = eh; v.e_data = ed; v.e_mse = em;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_sel = -1; m_err = 0; m_cnt = 0; m_mse = 1'b0; m_tmo = 1'b0;
    endtask

    task automatic model_out(output logic r, output logic rs, output logic [63:0] d);
        r = 1'b1; rs = 1'b0; d = '0;
        if (m_err == 2) begin
            r = 1'b0; rs = 1'b1;
        end else if (m_err == 1) begin
            rs = 1'b1;
        end else if (m_sel >= 0) begin
            r = HREADYOUT_S[m_sel]; rs = HRESP_S[m_sel]; d = HRDATA_S[m_sel];
        end
    endtask

    // Advance the model by one clock using the currently driven inputs.
    task automatic model_adv();
        logic r, rs;
        logic [63:0] d;
        int n, low;
        model_out(r, rs, d);
        if (ErrClr) begin
            m_mse = 1'b0; m_tmo = 1'b0;
        end
        if (m_err == 2) begin
            m_err = 1;
        end else if (r) begin
            m_err = 0; m_cnt = 0;
            if (HTRANS >= 2'd2) begin
                n = 0; low = -1;
                for (int i = NSLV - 1; i >= 0; i--) begin
                    if (HSEL[i]) begin n++; low = i; end
                end
                if (n > 0) begin
                    m_sel = low;
                    if (n > 1) m_mse = 1'b1;
                end else begin
                    m_sel = -1; m_err = 2;
                end
            end else begin
                m_sel = -1;
            end
        end
`ifdef AHB_RESP_MUX_TIMEOUT_EN
        else if (m_cnt == TMO) begin
            m_sel = -1; m_err = 2; m_tmo = 1'b1; m_cnt = 0;
        end else begin
            m_cnt++;
        end
`endif
    endtask

    task automatic check_model(input string tag);
        logic r, rs;
        logic [63:0] d;
        logic [7:0] eh;
        model_out(r, rs, d);
        eh = '0;
        if (m_sel >= 0) eh[m_sel] = 1'b1;
        chk({tag, "_hready"}, 64'(HREADY), 64'(r));
        chk({tag, "_hresp"},  64'(HRESP),  64'(rs));
        chk({tag, "_hrdata"}, HRDATA, d);
        chk({tag, "_hseld"},  64'(HSELD), 64'(eh));
        chk({tag, "_mse"},    64'(MultiSelErr), 64'(m_mse));
        chk({tag, "_tmo"},    64'(TmoErr), 64'(m_tmo));
    endtask

    task automatic tick();
        model_adv();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic drive(input logic [7:0] hsel, input logic [1:0] ht, input logic [7:0] rdy);
        HSEL = hsel; HTRANS = ht; HREADYOUT_S = rdy;
    endtask

    initial begin
        HRESETn = 1'b0; HSEL = '0; HTRANS = IDL; HREADYOUT_S = '1; HRESP_S = '0; ErrClr = 1'b0;
        for (int i = 0; i < NSLV; i++) HRDATA_S[i] = sdata(i);
        model_reset();

        tbl[0]  = mkv(8'h04, NSQ, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0);
        tbl[1]  = mkv(8'h00, IDL, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h04, sdata(2), 1'b0);
        tbl[2]  = mkv(8'h20, NSQ, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0);
        tbl[3]  = mkv(8'h01, NSQ, 8'hDF, 1'b0, 1'b0, 1'b0, 8'h20, sdata(5), 1'b0);
        tbl[4]  = mkv(8'h01, SEQ, 8'hDF, 1'b0, 1'b0, 1'b0, 8'h20, sdata(5), 1'b0);
        tbl[5]  = mkv(8'h01, NSQ, 8'hDF, 1'b0, 1'b0, 1'b0, 8'h20, sdata(5), 1'b0);
        tbl[6]  = mkv(8'h00, IDL, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h20, sdata(5), 1'b0);
        tbl[7]  = mkv(8'h00, NSQ, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0);
        tbl[8]  = mkv(8'h00, NSQ, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 64'h0, 1'b0);
        tbl[9]  = mkv(8'h00, NSQ, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h00, 64'h0, 1'b0);
        tbl[10] = mkv(8'h00, IDL, 8'hFF, 1'b0, 1'b0, 1'b1, 8'h00, 64'h0, 1'b0);
        tbl[11] = mkv(8'h00, IDL, 8'hFF, 1'b0, 1'b1, 1'b1, 8'h00, 64'h0, 1'b0);
        tbl[12] = mkv(8'h12, NSQ, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0);
        tbl[13] = mkv(8'h00, IDL, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h02, sdata(1), 1'b1);
        tbl[14] = mkv(8'h00, IDL, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b1);
        tbl[15] = mkv(8'h08, BSY, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0);
        tbl[16] = mkv(8'h00, IDL, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0);
        tbl[17] = mkv(8'h18, SEQ, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0);
        tbl[18] = mkv(8'h00, IDL, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h08, sdata(3), 1'b1);
        tbl[19] = mkv(8'h00, IDL, 8'hFF, 1'b1, 1'b1, 1'b0, 8'h00, 64'h0, 1'b1);
        tbl[20] = mkv(8'h00, IDL, 8'hFF, 1'b0, 1'b1, 1'b0, 8'h00, 64'h0, 1'b0);

        // Reset state.
        #1;
        chk("rst_hready", 64'(HREADY), 64'h1);
        chk("rst_hresp",  64'(HRESP),  64'h0);
        chk("rst_hrdata", HRDATA, 64'h0);
        chk("rst_hseld",  64'(HSELD), 64'h0);
        chk("rst_mse",    64'(MultiSelErr), 64'h0);
        chk("rst_tmo",    64'(TmoErr), 64'h0);
        @(negedge HCLK);
        @(negedge HCLK);
        HRESETn = 1'b1;

        // Directed vector table.
        for (int k = 0; k < NV; k++) begin
            drive(tbl[k].hsel, tbl[k].htrans, tbl[k].rdy);
            ErrClr = tbl[k].clr;
            #1;
            chk($sformatf("vec%0d_hready", k), 64'(HREADY), 64'(tbl[k].e_ready));
            chk($sformatf("vec%0d_hresp", k),  64'(HRESP),  64'(tbl[k].e_resp));
            chk($sformatf("vec%0d_hseld", k),  64'(HSELD),  64'(tbl[k].e_hseld));
            chk($sformatf("vec%0d_hrdata", k), HRDATA, tbl[k].e_data);
            chk($sformatf("vec%0d_mse", k),    64'(MultiSelErr), 64'(tbl[k].e_mse));
            chk($sformatf("vec%0d_tmo", k),    64'(TmoErr), 64'h0);
            tick();
        end
        ErrClr = 1'b0;

        // Asynchronous reset while in ERR1.
        drive(8'h00, NSQ, 8'hFF);
        #1; check_model("pre_err1");
        tick();
        drive(8'h00, IDL, 8'hFF);
        #1;
        chk("err1_hready", 64'(HREADY), 64'h0);
        chk("err1_hresp",  64'(HRESP),  64'h1);
        HRESETn = 1'b0;
        #1;
        chk("arst_hready", 64'(HREADY), 64'h1);
        chk("arst_hresp",  64'(HRESP),  64'h0);
        chk("arst_hseld",  64'(HSELD),  64'h0);
        model_reset();
        @(negedge HCLK);
        HRESETn = 1'b1;
        #1; check_model("post_arst");
        @(negedge HCLK);

        // Hung slave 0: stalls forever without the timeout, ERR pair with it.
        drive(8'h01, NSQ, 8'hFF);
        #1; check_model("hung_addr");
        tick();
        drive(8'h00, IDL, 8'hFE);
        for (int c = 0; c < 12; c++) begin
            #1; check_model($sformatf("hung%0d", c));
            tick();
        end
`ifdef AHB_RESP_MUX_TIMEOUT_EN
        chk("hung_tmoerr", 64'(TmoErr), 64'h1);
        chk("hung_hready", 64'(HREADY), 64'h1);
`else
        chk("hung_tmoerr", 64'(TmoErr), 64'h0);
        chk("hung_hready", 64'(HREADY), 64'h0);
`endif
        drive(8'h00, IDL, 8'hFF);
        ErrClr = 1'b1;
        #1; check_model("hung_release");
        tick();
        ErrClr = 1'b0;
        #1; check_model("hung_cleared");

        // Slave ready exactly when the wait count hits the limit: normal OKAY.
        drive(8'h01, NSQ, 8'hFF);
        #1; check_model("edge_addr");
        tick();
        drive(8'h00, IDL, 8'hFE);
        for (int c = 0; c < int'(TMO); c++) begin
            #1; check_model($sformatf("edge_wait%0d", c));
            tick();
        end
        drive(8'h00, IDL, 8'hFF);
        #1;
        chk("edge_hready", 64'(HREADY), 64'h1);
        chk("edge_hresp",  64'(HRESP),  64'h0);
        chk("edge_hrdata", HRDATA, sdata(0));
        tick();
        #1;
        chk("edge_tmoerr", 64'(TmoErr), 64'h0);
        check_model("edge_after");

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            @(negedge HCLK);
            case ($urandom_range(0, 3))
                0: HSEL = '0;
                1: HSEL = 8'(1) << $urandom_range(0, NSLV - 1);
                default: HSEL = 8'($urandom());
            endcase
            HTRANS = 2'($urandom());
            for (int i = 0; i < NSLV; i++) begin
                HREADYOUT_S[i] = ($urandom_range(0, 4) != 0);
                HRDATA_S[i]    = {$urandom(), $urandom()};
            end
            HRESP_S = 8'($urandom());
            ErrClr  = ($urandom_range(0, 15) == 0);
            #1; check_model($sformatf("rnd%0d", c));
            model_adv();
            @(posedge HCLK);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
